// File: rtl/adam_mem_arbiter_pkg.sv
// Shared types and helpers for the memory arbiter slice.
package adam_mem_arbiter_pkg;

  // Top-level power/quiesce state machine
  typedef enum logic [1:0] {
    PAUSED = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  // Width of a requester index; never narrower than one bit
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adam_rr_arbiter.sv
// Round-robin grant selection; owns the priority pointer.
module adam_rr_arbiter
  import adam_mem_arbiter_pkg::*;
#(
  parameter  int NO_REQS = 2,
  localparam int IDX_W   = idxWidth(NO_REQS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NO_REQS-1:0] elig_i,
  input  logic               advance_i,
  output logic [NO_REQS-1:0] grant_o,
  output logic [IDX_W-1:0]   grant_idx_o,
  output logic               grant_valid_o
);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] candIdx;

  // Search from the slot after the last winner, wrapping around once
  always_comb begin
    grant_o       = '0;
    grant_idx_o   = '0;
    grant_valid_o = 1'b0;
    candIdx       = '0;
    for (int k = 1; k <= NO_REQS; k++) begin
      candIdx = IDX_W'((int'(ptr_q) + k) % NO_REQS);
      if (!grant_valid_o && elig_i[candIdx]) begin
        grant_valid_o    = 1'b1;
        grant_o[candIdx] = 1'b1;
        grant_idx_o      = candIdx;
      end
    end
  end

  // Remember the winner so it drops to lowest priority next time
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= IDX_W'(NO_REQS - 1);
    end else if (advance_i && grant_valid_o) begin
      ptr_q <= grant_idx_o;
    end
  end

endmodule

// File: rtl/adam_mem_arbiter.sv
// Shares one single-port synchronous RAM between several valid/ready requesters,
// with a pause/drain handshake for quiescing the memory subsystem.
module adam_mem_arbiter
  import adam_mem_arbiter_pkg::*;
#(
  parameter  int NO_REQS    = 2,
  parameter  int ADDR_WIDTH = 32,
  parameter  int DATA_WIDTH = 32,
  localparam int STRB_WIDTH = DATA_WIDTH / 8,
  localparam int IDX_W      = idxWidth(NO_REQS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          pause_req,
  output logic                          pause_ack,
  input  logic [NO_REQS-1:0]            req_valid,
  output logic [NO_REQS-1:0]            req_ready,
  input  logic [NO_REQS-1:0]            req_we,
  input  logic [NO_REQS*ADDR_WIDTH-1:0] req_addr,
  input  logic [NO_REQS*DATA_WIDTH-1:0] req_wdata,
  input  logic [NO_REQS*STRB_WIDTH-1:0] req_strb,
  output logic [NO_REQS-1:0]            rsp_valid,
  input  logic [NO_REQS-1:0]            rsp_ready,
  output logic [NO_REQS*DATA_WIDTH-1:0] rsp_data,
  output logic                          mem_en,
  output logic [STRB_WIDTH-1:0]         mem_we,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0]         mem_wdata,
  input  logic [DATA_WIDTH-1:0]         mem_rdata
);

  state_t                        state_q;
  logic                          pauseAck_q;
  logic                          flightValid_q;
  logic [IDX_W-1:0]              flightId_q;
  logic                          flightWe_q;
  logic [NO_REQS-1:0]            holdValid_q;
  logic [NO_REQS-1:0][DATA_WIDTH-1:0] holdData_q;

  logic [NO_REQS-1:0]            elig;
  logic [NO_REQS-1:0]            grant;
  logic [IDX_W-1:0]              grantIdx;
  logic                          grantValid;
  logic                          runState;
  logic                          drainDone;
  logic [NO_REQS-1:0]            flightHit;
  logic [DATA_WIDTH-1:0]         flightData;

  assign runState  = (state_q == RUN);
  assign drainDone = !flightValid_q && !(|rsp_valid);
  assign pause_ack = pauseAck_q;
  assign req_ready = grant;

  // A requester may compete only if its response slot is free or being freed this cycle
  always_comb begin
    elig = req_valid & (~rsp_valid | rsp_ready) & {NO_REQS{runState}};
  end

  adam_rr_arbiter #(
    .NO_REQS (NO_REQS)
  ) u_rr (
    .clk           (clk),
    .rst_n         (rst_n),
    .elig_i        (elig),
    .advance_i     (runState),
    .grant_o       (grant),
    .grant_idx_o   (grantIdx),
    .grant_valid_o (grantValid)
  );

  // Quiesce state machine; the acknowledge trails the state by one register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= PAUSED;
      pauseAck_q <= 1'b1;
    end else begin
      pauseAck_q <= (state_q == PAUSED);
      unique case (state_q)
        PAUSED:  if (!pause_req) state_q <= RUN;
        RUN:     if (pause_req) state_q <= DRAIN;
        DRAIN: begin
          if (!pause_req) begin
            state_q <= RUN;
          end else if (drainDone) begin
            state_q <= PAUSED;
          end
        end
        default: state_q <= PAUSED;
      endcase
    end
  end

  // Route the winning requester onto the RAM pins; idle pins are held at zero
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grantValid) begin
      mem_en    = 1'b1;
      mem_addr  = req_addr[grantIdx*ADDR_WIDTH +: ADDR_WIDTH];
      mem_wdata = req_wdata[grantIdx*DATA_WIDTH +: DATA_WIDTH];
      mem_we    = req_we[grantIdx] ? req_strb[grantIdx*STRB_WIDTH +: STRB_WIDTH] : '0;
    end
  end

  // Track the access whose RAM data arrives next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flightValid_q <= 1'b0;
      flightId_q    <= '0;
      flightWe_q    <= 1'b0;
    end else begin
      flightValid_q <= grantValid;
      flightId_q    <= grantIdx;
      flightWe_q    <= req_we[grantIdx];
    end
  end

  // Present either the held response or the RAM data bypassed straight through
  always_comb begin
    rsp_valid  = '0;
    rsp_data   = '0;
    flightHit  = '0;
    flightData = flightWe_q ? '0 : mem_rdata;
    for (int i = 0; i < NO_REQS; i++) begin
      flightHit[i] = flightValid_q && (flightId_q == IDX_W'(i));
      rsp_valid[i] = holdValid_q[i] | flightHit[i];
      if (holdValid_q[i]) begin
        rsp_data[i*DATA_WIDTH +: DATA_WIDTH] = holdData_q[i];
      end else if (flightHit[i]) begin
        rsp_data[i*DATA_WIDTH +: DATA_WIDTH] = flightData;
      end
    end
  end

  // Park an unaccepted response so the RAM output can move on
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      holdValid_q <= '0;
      holdData_q  <= '0;
    end else begin
      for (int i = 0; i < NO_REQS; i++) begin
        if (flightHit[i] && !rsp_ready[i]) begin
          holdValid_q[i] <= 1'b1;
          holdData_q[i]  <= flightData;
        end else if (holdValid_q[i] && rsp_ready[i]) begin
          holdValid_q[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_adam_mem_arbiter.sv
// Directed bench for the memory arbiter with a per-requester response scoreboard.
module tb_adam_mem_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            pause_req;
  logic            pause_ack;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N*SW-1:0] req_strb;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready;
  logic [N*DW-1:0] rsp_data;
  logic            mem_en;
  logic [SW-1:0]   mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] expQ [N][$];
  logic [DW-1:0] expNext [N];
  logic          trackEn;
  logic [DW-1:0] ram [256];
  logic          ramLoaded = 1'b0;

  adam_mem_arbiter #(
    .NO_REQS    (N),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pause_req (pause_req),
    .pause_ack (pause_ack),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_strb  (req_strb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: one-cycle read latency, read-before-write, byte strobes
  always @(posedge clk) begin
    if (!ramLoaded) begin
      for (int a = 0; a < 256; a++) ram[a] <= '0;
      ram[8'h10] <= 32'hCAFEBABE;
      ram[8'h04] <= 32'h11223344;
      mem_rdata  <= '0;
      ramLoaded  <= 1'b1;
    end else if (mem_en) begin
      mem_rdata <= ram[mem_addr[7:0]];
      for (int b = 0; b < SW; b++) begin
        if (mem_we[b]) ram[mem_addr[7:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
    end
  end

  // Compare one observed value against its hand-computed expectation
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Wait, with a cycle budget, for requester id to be granted (sampled mid-cycle)
  task automatic waitGrant(input int id);
    bit got;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (req_ready[id]) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL grant_timeout: requester %0d got no grant in 20 cycles, required a grant", id);
    end
  endtask

  // Issue one request and hold it until granted
  task automatic applyStimulus(input int id, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] strb,
                               input logic [31:0] exp);
    req_we[id]                 = we;
    req_addr[id*AW +: AW]      = addr;
    req_wdata[id*DW +: DW]     = wdata;
    req_strb[id*SW +: SW]      = strb;
    expNext[id]                = exp;
    req_valid[id]              = 1'b1;
    waitGrant(id);
    @(posedge clk);
    #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Record expectations at grant time and retire them at each response handshake
  task automatic scoreboard();
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int i = 0; i < N; i++) begin
          if (rsp_valid[i] && rsp_ready[i]) begin
            if (expQ[i].size() == 0) begin
              checks++;
              errors++;
              $display("[TB] FAIL rsp_unexpected%0d: got 0x%08h with no request outstanding", i,
                       rsp_data[i*DW +: DW]);
            end else begin
              checkOutput($sformatf("rsp_data%0d", i), rsp_data[i*DW +: DW], expQ[i].pop_front());
            end
          end
          if (trackEn && req_valid[i] && req_ready[i]) expQ[i].push_back(expNext[i]);
        end
      end
    end
  endtask

  task automatic runTests();
    bit acked;
    bit granted;
    // Reset state
    #12;
    checkOutput("rst_pause_ack", 32'(pause_ack), 32'd1);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_mem_en", 32'(mem_en), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("ack_after_edge1", 32'(pause_ack), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("ack_after_edge2", 32'(pause_ack), 32'd0);

    // First read returns on the next cycle
    applyStimulus(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hCAFEBABE);
    checkOutput("rd_latency_valid", 32'(rsp_valid[0]), 32'd1);
    checkOutput("rd_latency_data", rsp_data[31:0], 32'hCAFEBABE);
    applyStimulus(1, 1'b0, 32'h10, 32'h0, 4'h0, 32'hCAFEBABE);
    idle(2);

    // Contention: grants alternate 0,1,0,1 with an access every cycle
    req_we = '0;
    req_addr = {32'h4, 32'h10};
    expNext[0] = 32'hCAFEBABE;
    expNext[1] = 32'h11223344;
    req_valid = 2'b11;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput($sformatf("rr_grant_c%0d", c), 32'(req_ready), (c % 2 == 0) ? 32'd1 : 32'd2);
      checkOutput($sformatf("rr_mem_en_c%0d", c), 32'(mem_en), 32'd1);
      @(posedge clk);
      #1;
    end
    req_valid = 2'b00;
    idle(2);

    // Backpressure on requester 1 while requester 0 overwrites the same word
    rsp_ready[1] = 1'b0;
    applyStimulus(1, 1'b0, 32'h4, 32'h0, 4'h0, 32'h11223344);
    req_we[1] = 1'b0;
    expNext[1] = 32'h55667788;
    req_valid[1] = 1'b1;
    req_we[0] = 1'b1;
    req_addr[31:0] = 32'h4;
    req_wdata[31:0] = 32'h55667788;
    req_strb[3:0] = 4'hF;
    expNext[0] = 32'h0;
    req_valid[0] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput($sformatf("bp_valid_c%0d", c), 32'(rsp_valid[1]), 32'd1);
      checkOutput($sformatf("bp_data_c%0d", c), rsp_data[63:32], 32'h11223344);
      checkOutput($sformatf("bp_no_regrant_c%0d", c), 32'(req_ready[1]), 32'd0);
      if (c == 0) checkOutput("bp_write_grant", 32'(req_ready[0]), 32'd1);
      @(posedge clk);
      #1;
      if (c == 0) req_valid[0] = 1'b0;
    end
    rsp_ready[1] = 1'b1;
    waitGrant(1);
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    idle(2);

    // Byte-masked write then read back
    applyStimulus(0, 1'b1, 32'h0, 32'hAABBCCDD, 4'b0101, 32'h0);
    applyStimulus(0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h00BB00DD);
    idle(2);

    // Pause during a stream
    req_we[0] = 1'b0;
    req_addr[31:0] = 32'h10;
    expNext[0] = 32'hCAFEBABE;
    req_valid[0] = 1'b1;
    idle(3);
    pause_req = 1'b1;
    @(negedge clk);
    checkOutput("pause_rise_grant", 32'(req_ready[0]), 32'd1);
    @(posedge clk);
    #1;
    acked = 1'b0;
    for (int c = 0; c < 10 && !acked; c++) begin
      @(negedge clk);
      checkOutput($sformatf("drain_no_grant_c%0d", c), 32'(req_ready), 32'd0);
      if (pause_ack) begin
        acked = 1'b1;
        checkOutput("ack_rsp_idle", 32'(rsp_valid), 32'd0);
      end
    end
    if (!acked) begin
      checks++;
      errors++;
      $display("[TB] FAIL pause_ack_timeout: pause_ack 0 after 10 cycles, required 1");
    end
    req_we[1] = 1'b0;
    req_addr[63:32] = 32'h4;
    expNext[1] = 32'h55667788;
    req_valid[1] = 1'b1;
    pause_req = 1'b0;
    granted = 1'b0;
    for (int c = 0; c < 10 && !granted; c++) begin
      @(negedge clk);
      if (|req_ready) begin
        granted = 1'b1;
        checkOutput("resume_grant", 32'(req_ready), 32'd2);
      end
    end
    if (!granted) begin
      checks++;
      errors++;
      $display("[TB] FAIL resume_timeout: no grant after pause release, required a grant");
    end
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    idle(3);
    checkOutput("q0_drained", 32'(expQ[0].size()), 32'd0);
    checkOutput("q1_drained", 32'(expQ[1].size()), 32'd0);

    // Asynchronous reset in the middle of an access
    trackEn = 1'b0;
    req_we[0] = 1'b0;
    req_addr[31:0] = 32'h10;
    req_valid[0] = 1'b1;
    waitGrant(0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("arst_mem_en", 32'(mem_en), 32'd0);
    checkOutput("arst_pause_ack", 32'(pause_ack), 32'd1);
    req_valid = 2'b00;
    idle(2);
  endtask

  initial begin
    rst_n     = 1'b0;
    pause_req = 1'b0;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_strb  = '0;
    rsp_ready = '1;
    trackEn   = 1'b1;
    expNext[0] = '0;
    expNext[1] = '0;
    fork
      scoreboard();
      runTests();
    join_any
    disable fork;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
